maindec_fsm: RTL and testbench

Multicycle successor to the single-cycle MIPS main decoder: a Moore/Mealy control FSM that sequences each instruction over 3–5 cycles through a shared ALU and a single unified memory port. It sits between the instruction register and the datapath muxes/enables. It adds a memory ready handshake with a parametrised timeout, and single-cycle error pulses for illegal opcodes and bus timeouts.

---
 rtl/maindec_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_maindec_fsm.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maindec_fsm.sv
// Multicycle MIPS main-decoder control FSM with memory ready handshake, bus timeout and illegal-op pulses.
// Optional feature macro: BNE_EN (adds BNE decode; op 000101 is illegal when undefined).
module maindec_fsm #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       memread_o,
    output logic       memwrite_o,
    output logic       iord_o,
    output logic       irwrite_o,
    output logic       regwrite_o,
    output logic       regdst_o,
    output logic       memtoreg_o,
    output logic       alusrca_o,
    output logic [1:0] alusrcb_o,
    output logic [1:0] aluop_o,
    output logic [1:0] pcsrc_o,
    output logic       pcwrite_o,
    output logic [3:0] state_o,
    output logic       illegal_op_o,
    output logic       bus_err_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_IEXE   = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_C = TIMEOUT_W'(TIMEOUT);

    state_e               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    logic       memread_s, memwrite_s, iord_s, irwrite_s;
    logic       regwrite_s, regdst_s, memtoreg_s, alusrca_s;
    logic [1:0] alusrcb_s, aluop_s, pcsrc_s;
    logic       pcwrite_s, illegal_op_s, bus_err_s;
    logic       wait_s, timeout_s;
    logic       unused_funct_s;

    // funct only feeds the ALU decoder downstream.
    assign unused_funct_s = ^funct_i;
    assign timeout_s      = (cnt_q == TIMEOUT_C);

    // State and wait-counter registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q <= S_FETCH;
            cnt_q   <= {TIMEOUT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, control outputs and wait-counter update.
    always_comb begin
        state_d      = state_q;
        memread_s    = 1'b0;
        memwrite_s   = 1'b0;
        iord_s       = 1'b0;
        irwrite_s    = 1'b0;
        regwrite_s   = 1'b0;
        regdst_s     = 1'b0;
        memtoreg_s   = 1'b0;
        alusrca_s    = 1'b0;
        alusrcb_s    = 2'b00;
        aluop_s      = 2'b00;
        pcsrc_s      = 2'b00;
        pcwrite_s    = 1'b0;
        illegal_op_s = 1'b0;
        bus_err_s    = 1'b0;
        wait_s       = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread_s = 1'b1;
                if (mem_ready_i) begin
                    irwrite_s = 1'b1;
                    pcwrite_s = 1'b1;
                    alusrcb_s = 2'b01;
                    state_d   = S_DECODE;
                end else if (timeout_s) begin
                    bus_err_s = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_s = 1'b1;
                end
            end
            S_DECODE: begin
                alusrcb_s = 2'b11;
                casez (op_i)
                    OP_RTYPE:  state_d = S_RTEXE;
                    6'b001???: state_d = S_IEXE;
                    OP_LW,
                    OP_SW:     state_d = S_MEMADR;
                    OP_BEQ:    state_d = S_BRANCH;
`ifdef BNE_EN
                    OP_BNE:    state_d = S_BRANCH;
`endif
                    OP_J:      state_d = S_JUMP;
                    default: begin
                        illegal_op_s = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (op_i == OP_LW) begin
                    state_d = S_MEMRD;
                end else begin
                    state_d = S_MEMWR;
                end
            end
            S_MEMRD: begin
                iord_s    = 1'b1;
                memread_s = 1'b1;
                if (mem_ready_i) begin
                    state_d = S_MEMWB;
                end else if (timeout_s) begin
                    bus_err_s = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_s = 1'b1;
                end
            end
            S_MEMWB: begin
                regwrite_s = 1'b1;
                memtoreg_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                // A timed-out store simply returns to FETCH; the write is dropped.
                if (mem_ready_i) begin
                    state_d = S_FETCH;
                end else if (timeout_s) begin
                    bus_err_s = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    wait_s = 1'b1;
                end
            end
            S_RTEXE: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b10;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                regwrite_s = 1'b1;
                regdst_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEXE: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                aluop_s   = 2'b11;
                state_d   = S_IWB;
            end
            S_IWB: begin
                regwrite_s = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = 2'b01;
                pcsrc_s   = 2'b01;
`ifdef BNE_EN
                if (op_i == OP_BNE) begin
                    pcwrite_s = ~zero_i;
                end else begin
                    pcwrite_s = zero_i;
                end
`else
                pcwrite_s = zero_i;
`endif
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s   = 2'b10;
                pcwrite_s = 1'b1;
                state_d   = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (bus_err_s || (state_d != state_q)) begin
            cnt_d = {TIMEOUT_W{1'b0}};
        end else if (wait_s) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Every output, including the debug state, reads 0 while reset is held.
    assign memread_o    = resetn_i & memread_s;
    assign memwrite_o   = resetn_i & memwrite_s;
    assign iord_o       = resetn_i & iord_s;
    assign irwrite_o    = resetn_i & irwrite_s;
    assign regwrite_o   = resetn_i & regwrite_s;
    assign regdst_o     = resetn_i & regdst_s;
    assign memtoreg_o   = resetn_i & memtoreg_s;
    assign alusrca_o    = resetn_i & alusrca_s;
    assign alusrcb_o    = {2{resetn_i}} & alusrcb_s;
    assign aluop_o      = {2{resetn_i}} & aluop_s;
    assign pcsrc_o      = {2{resetn_i}} & pcsrc_s;
    assign pcwrite_o    = resetn_i & pcwrite_s;
    assign state_o      = {4{resetn_i}} & state_q;
    assign illegal_op_o = resetn_i & illegal_op_s;
    assign bus_err_o    = resetn_i & bus_err_s;

endmodule

// File: tb/tb_maindec_fsm.sv
// Bench for maindec_fsm: directed vector table, hand-written wait/timeout/reset sequences,
// and randomized traffic checked against an instruction-plan reference model.
module tb_maindec_fsm;

    localparam int TW = 4;
    localparam int TO = 4;
`ifdef BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif

    localparam logic [5:0] LW = 6'h23, SW = 6'h2b, ADDI = 6'h08, RT = 6'h00;
    localparam logic [5:0] BEQ = 6'h04, BNEOP = 6'h05, JOP = 6'h02, BAD = 6'h3f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn, zero, ready;
    logic [5:0] op, funct;
    logic       memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       pcwrite, illegal_op, bus_err;
    logic [3:0] state;

    maindec_fsm #(.TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .resetn_i(resetn), .op_i(op), .funct_i(funct), .zero_i(zero),
        .mem_ready_i(ready), .memread_o(memread), .memwrite_o(memwrite), .iord_o(iord),
        .irwrite_o(irwrite), .regwrite_o(regwrite), .regdst_o(regdst), .memtoreg_o(memtoreg),
        .alusrca_o(alusrca), .alusrcb_o(alusrcb), .aluop_o(aluop), .pcsrc_o(pcsrc),
        .pcwrite_o(pcwrite), .state_o(state), .illegal_op_o(illegal_op), .bus_err_o(bus_err)
    );

    // fl = {memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca}
    typedef struct packed {
        logic [3:0] st;
        logic [7:0] fl;
        logic [1:0] asb, aop, pcs;
        logic       pcw, ill, berr;
    } outs_t;

    typedef struct {
        logic       rn;
        logic [5:0] op;
        logic       z, rdy;
        outs_t      exp;
    } vec_t;

    outs_t act_s, got;
    assign act_s = {state, {memread, memwrite, iord, irwrite, regwrite, regdst, memtoreg, alusrca},
                    alusrcb, aluop, pcsrc, pcwrite, illegal_op, bus_err};

    int tests = 0, fails = 0;

    // Reference model: current state, wait count and the remaining state plan of this instruction.
    int         m_st = 0, m_cnt = 0;
    int         plan[$];
    logic [5:0] m_op = 6'h00;

    function automatic outs_t mkv(input logic [3:0] st, input logic [7:0] fl, input logic [1:0] asb,
                                  input logic [1:0] aop, input logic [1:0] pcs, input logic pcw,
                                  input logic ill, input logic berr);
        return {st, fl, asb, aop, pcs, pcw, ill, berr};
    endfunction

    // Instruction class: 0 illegal, 1 R, 2 imm, 3 LW, 4 SW, 5 branch, 6 jump.
    function automatic int cls(input logic [5:0] o);
        if (o == RT) return 1;
        if (o[5:3] == 3'b001) return 2;
        if (o == LW) return 3;
        if (o == SW) return 4;
        if (o == BEQ || (BNE && o == BNEOP)) return 5;
        if (o == JOP) return 6;
        return 0;
    endfunction

    function automatic outs_t base(input int s);
        logic [3:0] s4;
        s4 = 4'(s);
        case (s)
            0:  return mkv(s4, 8'b1000_0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            1:  return mkv(s4, 8'b0000_0000, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            2:  return mkv(s4, 8'b0000_0001, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            3:  return mkv(s4, 8'b1010_0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            4:  return mkv(s4, 8'b0000_1010, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            5:  return mkv(s4, 8'b0110_0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            6:  return mkv(s4, 8'b0000_0001, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0);
            7:  return mkv(s4, 8'b0000_1100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            8:  return mkv(s4, 8'b0000_0001, 2'd2, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0);
            9:  return mkv(s4, 8'b0000_1000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
            10: return mkv(s4, 8'b0000_0001, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
            11: return mkv(s4, 8'b0000_0000, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0);
            default: return '0;
        endcase
    endfunction

    function automatic bit is_mem(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    function automatic outs_t model_out(input logic rn, input logic [5:0] o, input logic z, input logic rdy);
        outs_t e;
        if (!rn) return '0;
        e = base(m_st);
        if (is_mem(m_st)) begin
            if (rdy && m_st == 0) begin
                e.fl[4] = 1'b1;
                e.pcw   = 1'b1;
                e.asb   = 2'b01;
            end else if (!rdy && m_cnt == TO) begin
                e.berr = 1'b1;
            end
        end
        if (m_st == 1 && cls(o) == 0) e.ill = 1'b1;
        if (m_st == 10) e.pcw = (m_op == BNEOP) ? ~z : z;
        return e;
    endfunction

    task automatic advance();
        if (plan.size() == 0) m_st = 0;
        else m_st = plan.pop_front();
    endtask

    task automatic model_step(input logic rn, input logic [5:0] o, input logic rdy);
        if (!rn) begin
            m_st = 0; m_cnt = 0; plan.delete();
        end else if (is_mem(m_st)) begin
            if (rdy) begin
                m_cnt = 0;
                if (m_st == 0) m_st = 1;
                else advance();
            end else if (m_cnt == TO) begin
                m_cnt = 0; m_st = 0; plan.delete();
            end else begin
                m_cnt++;
            end
        end else if (m_st == 1) begin
            m_op = o;
            plan.delete();
            case (cls(o))
                1: plan = '{6, 7};
                2: plan = '{8, 9};
                3: plan = '{2, 3, 4};
                4: plan = '{2, 5};
                5: plan = '{10};
                6: plan = '{11};
                default: plan.delete();
            endcase
            advance();
        end else begin
            advance();
        end
    endtask

    task automatic chk(input string name, input outs_t a, input outs_t e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h, required %h (model state %0d, t=%0t)", name, a, e, m_st, $time);
        end
    endtask

    task automatic dchk(input string name, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, a, e, $time);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns later, check against the model.
    task automatic step(input logic rn, input logic [5:0] o, input logic z, input logic rdy);
        outs_t e;
        @(negedge clk);
        resetn = rn; op = o; zero = z; ready = rdy; funct = 6'($urandom);
        #1;
        got = act_s;
        e = model_out(rn, o, z, rdy);
        chk("model", got, e);
        model_step(rn, o, rdy);
    endtask

    task automatic to_memstate(input logic [5:0] o);
        step(1'b0, o, 1'b0, 1'b1);
        step(1'b1, o, 1'b0, 1'b1);
        step(1'b1, o, 1'b0, 1'b1);
        step(1'b1, o, 1'b0, 1'b1);
    endtask

    vec_t tbl[$];

    task automatic add(input logic rn, input logic [5:0] o, input logic z, input logic rdy, input outs_t e);
        vec_t v;
        v.rn = rn; v.op = o; v.z = z; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endtask

    outs_t      fe, de;
    logic [5:0] cur_op;
    logic       rn_r, rdy_r;
    int         stall;

    initial begin
        resetn = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; ready = 1'b0;
        fe = mkv(4'd0, 8'b1001_0000, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
        de = mkv(4'd1, 8'b0000_0000, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

        add(1'b0, LW, 1'b0, 1'b1, '0);
        add(1'b1, LW, 1'b0, 1'b1, fe);
        add(1'b1, LW, 1'b0, 1'b1, de);
        add(1'b1, LW, 1'b0, 1'b1, mkv(4'd2, 8'b0000_0001, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, LW, 1'b0, 1'b1, mkv(4'd3, 8'b1010_0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, LW, 1'b0, 1'b1, mkv(4'd4, 8'b0000_1010, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, ADDI, 1'b0, 1'b1, fe);
        add(1'b1, ADDI, 1'b0, 1'b1, de);
        add(1'b1, ADDI, 1'b0, 1'b1, mkv(4'd8, 8'b0000_0001, 2'd2, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, ADDI, 1'b0, 1'b1, mkv(4'd9, 8'b0000_1000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, RT, 1'b0, 1'b1, fe);
        add(1'b1, RT, 1'b0, 1'b1, de);
        add(1'b1, RT, 1'b0, 1'b1, mkv(4'd6, 8'b0000_0001, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, RT, 1'b0, 1'b1, mkv(4'd7, 8'b0000_1100, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, BEQ, 1'b1, 1'b1, fe);
        add(1'b1, BEQ, 1'b1, 1'b1, de);
        add(1'b1, BEQ, 1'b1, 1'b1, mkv(4'd10, 8'b0000_0001, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 1'b0));
        add(1'b1, BEQ, 1'b0, 1'b1, fe);
        add(1'b1, BEQ, 1'b0, 1'b1, de);
        add(1'b1, BEQ, 1'b0, 1'b1, mkv(4'd10, 8'b0000_0001, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0));
        add(1'b1, JOP, 1'b0, 1'b1, fe);
        add(1'b1, JOP, 1'b0, 1'b1, de);
        add(1'b1, JOP, 1'b0, 1'b1, mkv(4'd11, 8'b0000_0000, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0));
        add(1'b1, BAD, 1'b0, 1'b1, fe);
        add(1'b1, BAD, 1'b0, 1'b1, mkv(4'd1, 8'b0000_0000, 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0));
        add(1'b1, SW, 1'b0, 1'b1, fe);
        add(1'b1, SW, 1'b0, 1'b1, de);
        add(1'b1, SW, 1'b0, 1'b1, mkv(4'd2, 8'b0000_0001, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, SW, 1'b0, 1'b1, mkv(4'd5, 8'b0110_0000, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0));
        add(1'b1, SW, 1'b0, 1'b1, fe);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rn, tbl[i].op, tbl[i].z, tbl[i].rdy);
            chk($sformatf("table[%0d]", i), got, tbl[i].exp);
        end

        // SW with three wait cycles: MEMWR held, no bus error.
        to_memstate(SW);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, SW, 1'b0, 1'b0);
            dchk("sw_wait_state", int'(got.st), 5);
            dchk("sw_wait_memwrite", int'(got.fl[6]), 1);
            dchk("sw_wait_no_berr", int'(got.berr), 0);
        end
        step(1'b1, SW, 1'b0, 1'b1);
        dchk("sw_done_memwrite", int'(got.fl[6]), 1);
        step(1'b1, SW, 1'b0, 1'b0);
        dchk("sw_back_fetch", int'(got.st), 0);

        // LW read timing out after TO wait cycles.
        to_memstate(LW);
        for (int i = 0; i < TO; i++) begin
            step(1'b1, LW, 1'b0, 1'b0);
            dchk("lw_to_pre_berr", int'(got.berr), 0);
        end
        step(1'b1, LW, 1'b0, 1'b0);
        dchk("lw_to_berr", int'(got.berr), 1);
        dchk("lw_to_berr_state", int'(got.st), 3);
        step(1'b1, LW, 1'b0, 1'b0);
        dchk("lw_to_fetch", int'(got.st), 0);
        dchk("lw_to_single_pulse", int'(got.berr), 0);

        // Ready arriving in the timeout cycle completes the access.
        to_memstate(LW);
        for (int i = 0; i < TO; i++) step(1'b1, LW, 1'b0, 1'b0);
        step(1'b1, LW, 1'b0, 1'b1);
        dchk("ready_wins_no_berr", int'(got.berr), 0);
        step(1'b1, LW, 1'b0, 1'b1);
        dchk("ready_wins_memwb", int'(got.st), 4);

        // Reset asserted in MEMRD abandons the access.
        to_memstate(LW);
        step(1'b0, LW, 1'b0, 1'b1);
        dchk("rst_mid_all_zero", int'(got), 0);
        step(1'b1, LW, 1'b0, 1'b1);
        chk("rst_mid_refetch", got, fe);
        step(1'b1, LW, 1'b0, 1'b1);
        dchk("rst_mid_decode", int'(got.st), 1);

        // Instruction fetch stuck: bus error in FETCH, then a fresh wait count.
        step(1'b0, LW, 1'b0, 1'b0);
        for (int i = 0; i < TO; i++) step(1'b1, LW, 1'b0, 1'b0);
        step(1'b1, LW, 1'b0, 1'b0);
        dchk("fetch_to_berr", int'(got.berr), 1);
        dchk("fetch_to_state", int'(got.st), 0);
        step(1'b1, LW, 1'b0, 1'b0);
        dchk("fetch_to_cleared", int'(got.berr), 0);

        // op 000101: BNE when enabled, illegal otherwise.
        step(1'b0, BNEOP, 1'b1, 1'b1);
        step(1'b1, BNEOP, 1'b1, 1'b1);
        step(1'b1, BNEOP, 1'b1, 1'b1);
`ifdef BNE_EN
        dchk("bne_decode_legal", int'(got.ill), 0);
        step(1'b1, BNEOP, 1'b1, 1'b1);
        dchk("bne_state", int'(got.st), 10);
        dchk("bne_zero1_no_pcw", int'(got.pcw), 0);
`else
        dchk("bne_illegal", int'(got.ill), 1);
        step(1'b1, BNEOP, 1'b1, 1'b1);
        dchk("bne_illegal_fetch", int'(got.st), 0);
`endif

        // Randomized traffic against the model.
        step(1'b0, LW, 1'b0, 1'b1);
        stall  = 0;
        cur_op = LW;
        for (int i = 0; i < 4000; i++) begin
            if (m_st == 0) begin
                case ($urandom_range(0, 9))
                    0: cur_op = RT;
                    1: cur_op = {3'b001, 3'($urandom)};
                    2, 8: cur_op = LW;
                    3, 9: cur_op = SW;
                    4: cur_op = BEQ;
                    5: cur_op = JOP;
                    6: cur_op = BNEOP;
                    default: cur_op = 6'($urandom);
                endcase
            end
            if (stall > 0) begin
                rdy_r = 1'b0;
                stall--;
            end else begin
                rdy_r = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 39) == 0) stall = $urandom_range(3, 8);
            end
            rn_r = ($urandom_range(0, 99) != 0);
            step(rn_r, cur_op, 1'($urandom), rdy_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
